// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared encodings for the memory port arbiter:
//   - owner_e : which requester the read data arriving this cycle belongs to
//   - gnt_e   : grant decision for the current cycle
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, data requester and memory macro signals.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants,
//            responses and the memory strobe/address/data).
//   master : environment view (core requesters plus memory macro).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;
    // load/store requester
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;
    // memory macro
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter_arb_prio.sv
// arb_prio
//   Combinational priority pick between fetch and data requests.
//   Data wins contention until starve_cnt reaches MAX_D_BURST, then fetch.
//   Ports: if_req, d_req, starve_cnt in; gnt (gnt_e) out.
module arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_BURST = 4,
    parameter int CNT_W       = $clog2(MAX_D_BURST + 1)
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output gnt_e             gnt
);

    always_comb begin
        gnt = GNT_NONE;
        if (if_req && d_req)
            gnt = (starve_cnt == CNT_W'(MAX_D_BURST)) ? GNT_IF : GNT_D;
        else if (if_req)
            gnt = GNT_IF;
        else if (d_req)
            gnt = GNT_D;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous memory port between instruction fetch and the
//   load/store path. One grant per cycle, zero-cycle grant, read data
//   returns one cycle later to whichever requester issued the read.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - mem_port_arbiter_if.slave (requesters + memory macro)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_port_arbiter_if.slave      bus
);

    localparam int CNT_W = $clog2(MAX_D_BURST + 1);
    localparam int BE_W  = DATA_W / 8;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_D_BURST);

    gnt_e              gnt_raw;
    gnt_e              gnt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_d;
    owner_e            owner_q;
    owner_e            owner_d;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] d_hold;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;

    arb_prio #(
        .MAX_D_BURST (MAX_D_BURST),
        .CNT_W       (CNT_W)
    ) u_prio (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .starve_cnt (starve_cnt),
        .gnt        (gnt_raw)
    );

    // Reset blocks the grant outright so nothing reaches memory while
    // the owner/counter state is being cleared.
    assign gnt        = rst ? GNT_NONE : gnt_raw;
    assign bus.if_gnt = (gnt == GNT_IF);
    assign bus.d_gnt  = (gnt == GNT_D);

    // Memory request mux: idle port drives all zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        case (gnt)
            GNT_IF: begin
                mem_en   = 1'b1;
                mem_addr = bus.if_addr;
                mem_be   = '1;
            end
            GNT_D: begin
                mem_en    = 1'b1;
                mem_we    = bus.d_we;
                mem_addr  = bus.d_addr;
                mem_wdata = bus.d_wdata;
                mem_be    = bus.d_be;
            end
            default: ;
        endcase
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_be    = mem_be;

    // Starvation counter: counts data grants that bypassed a waiting fetch.
    // Anything else (fetch grant, fetch not waiting) clears it.
    always_comb begin
        starve_d = '0;
        if (gnt == GNT_D && bus.if_req)
            starve_d = (starve_cnt == MAX_CNT) ? MAX_CNT : starve_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) starve_cnt <= '0;
        else     starve_cnt <= starve_d;
    end

    // Response owner: state register
    always_ff @(posedge clk) begin
        if (rst) owner_q <= OWN_NONE;
        else     owner_q <= owner_d;
    end

    // Response owner: next state. Stores never produce a response.
    always_comb begin
        owner_d = OWN_NONE;
        if (gnt == GNT_IF)
            owner_d = OWN_IF;
        else if (gnt == GNT_D && !bus.d_we)
            owner_d = OWN_D;
    end

    // Response owner: outputs. The owner sees mem_rdata directly; the
    // other requester keeps seeing its last delivered word.
    assign bus.if_rvalid = (owner_q == OWN_IF);
    assign bus.d_rvalid  = (owner_q == OWN_D);
    assign bus.if_rdata  = (owner_q == OWN_IF) ? bus.mem_rdata : if_hold;
    assign bus.d_rdata   = (owner_q == OWN_D)  ? bus.mem_rdata : d_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_hold <= '0;
            d_hold  <= '0;
        end else begin
            if (owner_q == OWN_IF) if_hold <= bus.mem_rdata;
            if (owner_q == OWN_D)  d_hold  <= bus.mem_rdata;
        end
    end

endmodule
